// File: rtl/proc_modem_pkg.sv
// Shared types and helpers for the modem channel scheduler.
// Holds the FSM state encoding and the round-robin step function.
package proc_modem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    localparam int SYM_CLKS_DEF = 32;

    function automatic int next_rr(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/proc_modem_sched_if.sv
// Requester/modem bundle between the scheduler and its clients.
// master drives requests and demod return; slave is the scheduler.
interface proc_modem_sched_if #(
    parameter int N_REQ = 4
);
    localparam int OW = $clog2(N_REQ);

    logic             enable;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] key;
    logic             demod_in;
    logic             fault_clr;
    logic             mod_out;
    logic [N_REQ-1:0] grant;
    logic [OW-1:0]    owner;
    logic             busy;
    logic             overrun;
    logic             echo_fault;

    modport master (
        output enable, req, key, demod_in, fault_clr,
        input  mod_out, grant, owner, busy, overrun, echo_fault
    );

    modport slave (
        input  enable, req, key, demod_in, fault_clr,
        output mod_out, grant, owner, busy, overrun, echo_fault
    );

endinterface

// File: rtl/proc_modem_rr_pick.sv
// Combinational round-robin picker: first requester after the last owner.
// Produces a one-hot pick and its index; zero when nobody requests.
module proc_modem_rr_pick
    import proc_modem_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int OW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [OW-1:0]    owner_i,
    output logic [N_REQ-1:0] pick_o,
    output logic [OW-1:0]    pick_idx_o
);

    logic [OW-1:0] cand;
    logic          found;

    always_comb begin
        pick_o     = '0;
        pick_idx_o = '0;
        found      = 1'b0;
        cand       = OW'(next_rr(int'(owner_i), N_REQ));
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                pick_o[cand] = 1'b1;
                pick_idx_o   = cand;
            end
            cand = OW'(next_rr(int'(cand), N_REQ));
        end
    end

endmodule

// File: rtl/proc_modem_sched.sv
// Shares one modem keying bit between N_REQ requesters on symbol boundaries,
// with a forced-0 guard between owners and an echo check on rising keys.
module proc_modem_sched
    import proc_modem_pkg::*;
#(
    parameter int N_REQ            = 4,
    parameter int SYM_CLKS         = SYM_CLKS_DEF,
    parameter int GUARD_SYMBOLS    = 2,
    parameter int MAX_HOLD_SYMBOLS = 64,
    parameter int ECHO_SYMBOLS     = 4
) (
    input logic               clock,
    input logic               reset_n,
    proc_modem_sched_if.slave bus
);

    localparam int OW = $clog2(N_REQ);
    localparam int SW = $clog2(SYM_CLKS);
    localparam int HW = $clog2(MAX_HOLD_SYMBOLS + 1);
    localparam int GW = $clog2(GUARD_SYMBOLS + 1);
    localparam int EW = $clog2(ECHO_SYMBOLS + 1);

    state_t           state_q, state_d;
    logic [SW-1:0]    sym_cnt_q, sym_cnt_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [GW-1:0]    guard_cnt_q, guard_cnt_d;
    logic [EW-1:0]    echo_cnt_q, echo_cnt_d;
    logic             echo_act_q, echo_act_d;
    logic             echo_fault_q, echo_fault_d;
    logic             overrun_q, overrun_d;
    logic             mod_out_q, mod_out_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [OW-1:0]    owner_q, owner_d;

    logic             sym_tick;
    logic             rel;
    logic [N_REQ-1:0] pick_oh;
    logic [OW-1:0]    pick_idx;

    assign sym_tick  = (sym_cnt_q == SW'(SYM_CLKS - 1));
    assign sym_cnt_d = sym_tick ? '0 : sym_cnt_q + SW'(1);

    proc_modem_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i      (bus.req),
        .owner_i    (owner_q),
        .pick_o     (pick_oh),
        .pick_idx_o (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        mod_out_d    = 1'b0;
        hold_cnt_d   = hold_cnt_q;
        guard_cnt_d  = guard_cnt_q;
        overrun_d    = 1'b0;
        echo_act_d   = echo_act_q;
        echo_cnt_d   = echo_cnt_q;
        echo_fault_d = echo_fault_q & ~bus.fault_clr;
        rel          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (sym_tick && bus.enable && |bus.req) begin
                    state_d    = ST_HOLD;
                    grant_d    = pick_oh;
                    owner_d    = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                mod_out_d = bus.key[owner_q];
                // enable drop releases immediately, off the symbol grid
                if (!bus.enable) begin
                    rel = 1'b1;
                end else if (sym_tick) begin
                    if (hold_cnt_q == HW'(MAX_HOLD_SYMBOLS - 1)) begin
                        rel       = 1'b1;
                        overrun_d = 1'b1;
                    end else if (!bus.req[owner_q]) begin
                        rel = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
            end
            ST_GUARD: begin
                if (sym_tick) begin
                    if (guard_cnt_q == GW'(GUARD_SYMBOLS - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        guard_cnt_d = guard_cnt_q + GW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rel) begin
            state_d     = ST_GUARD;
            grant_d     = '0;
            mod_out_d   = 1'b0;
            guard_cnt_d = '0;
        end

        // leaving HOLD abandons a pending echo check silently
        if (state_q != ST_HOLD || state_d != ST_HOLD) begin
            echo_act_d = 1'b0;
        end else if (mod_out_d && !mod_out_q) begin
            echo_act_d = 1'b1;
            echo_cnt_d = '0;
        end else if (echo_act_q) begin
            if (bus.demod_in) begin
                echo_act_d = 1'b0;
            end else if (sym_tick) begin
                if (echo_cnt_q == EW'(ECHO_SYMBOLS - 1)) begin
                    echo_act_d   = 1'b0;
                    echo_fault_d = 1'b1;
                end else begin
                    echo_cnt_d = echo_cnt_q + EW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            sym_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            guard_cnt_q  <= '0;
            echo_cnt_q   <= '0;
            echo_act_q   <= 1'b0;
            echo_fault_q <= 1'b0;
            overrun_q    <= 1'b0;
            mod_out_q    <= 1'b0;
            grant_q      <= '0;
            owner_q      <= OW'(N_REQ - 1);
        end else begin
            state_q      <= state_d;
            sym_cnt_q    <= sym_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            guard_cnt_q  <= guard_cnt_d;
            echo_cnt_q   <= echo_cnt_d;
            echo_act_q   <= echo_act_d;
            echo_fault_q <= echo_fault_d;
            overrun_q    <= overrun_d;
            mod_out_q    <= mod_out_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
        end
    end

    assign bus.mod_out    = mod_out_q;
    assign bus.grant      = grant_q;
    assign bus.owner      = owner_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.overrun    = overrun_q;
    assign bus.echo_fault = echo_fault_q;

endmodule

// File: doc/proc_modem_sched.md
# proc_modem_sched

Round-robin scheduler that shares one modem transmit channel (the modulator's `virtual_out` keying bit) between `N_REQ` requesters and supervises the demodulated return (`virtual_in`). Ownership changes only on modem symbol boundaries. A forced idle guard separates owners so the far-end demodulator always sees a valid 0 between owners. Sits between the DIOB processing plugins and one modem channel instance.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `SYM_CLKS`, 32, clocks per modem symbol (one 3.90625 MHz carrier period at 125 MHz)
- `GUARD_SYMBOLS`, 2, forced-0 symbols between owners (>=1)
- `MAX_HOLD_SYMBOLS`, 64, maximum symbols one owner may hold the channel
- `ECHO_SYMBOLS`, 4, symbols allowed for `demod_in` to follow a rising key
- `clock`  in  1  125 MHz system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  scheduler enable; low forces release and idle
- `req`  in  N_REQ  per-requester channel request (level)
- `key`  in  N_REQ  per-requester requested TX level
- `demod_in`  in  1  demodulated input from modem (`virtual_in`)
- `fault_clr`  in  1  clears `echo_fault` (single-cycle pulse)
- `mod_out`  out  1  keying bit to modem (`virtual_out`)
- `grant`  out  N_REQ  one-hot owner, 0 when none
- `owner`  out  $clog2(N_REQ)  index of current/last owner
- `busy`  out  1  high in HOLD or GUARD
- `overrun`  out  1  one-cycle pulse on forced release at MAX_HOLD_SYMBOLS
- `echo_fault`  out  1  sticky: keyed 1 not echoed on `demod_in` in time

## Operation
- Free-running symbol counter 0..SYM_CLKS-1. `sym_tick` = counter at SYM_CLKS-1. All state transitions except enable-drop happen on `sym_tick`.
- States: IDLE, HOLD, GUARD.
- IDLE: `grant`=0, `mod_out`=0. On `sym_tick` with `enable` and `|req`: select the first requester at or after `owner+1` modulo N_REQ. Load `grant`/`owner`, clear `hold_cnt`, go to HOLD.
- HOLD: `mod_out` <= `key[owner]` every clock. On `sym_tick`, `hold_cnt`++. Release when `!req[owner]` or `hold_cnt`==MAX_HOLD_SYMBOLS-1; release is evaluated on `sym_tick`. Release action: `grant`<=0, `mod_out`<=0, `guard_cnt`<=0, go to GUARD. A MAX_HOLD release also pulses `overrun`.
- `enable` low in HOLD: release on the next clock, not waiting for `sym_tick`. No `overrun` pulse.
- GUARD: `mod_out`=0. On `sym_tick`, `guard_cnt`++. At `guard_cnt`==GUARD_SYMBOLS-1 go to IDLE. `enable` low in IDLE/GUARD holds IDLE/GUARD (GUARD still completes).
- Echo check, active in HOLD only: a rising edge of the key driven to `mod_out` starts `echo_cnt`=0. `echo_cnt` increments on `sym_tick`. `demod_in`=1 stops the check. If `echo_cnt` reaches ECHO_SYMBOLS with no echo, set `echo_fault`. Leaving HOLD aborts the check without a fault.
- `fault_clr` clears `echo_fault`. A fault set in the same cycle as `fault_clr` wins.
- Round-robin pointer is `owner`. It updates only on grant and keeps its value across IDLE.
- Counters are saturating-free. Widths are sized by $clog2 of each bound; wrap never occurs because each compare resets the counter.

## Timing
- Reset values: state IDLE; `mod_out`=0, `grant`=0, `owner`=N_REQ-1 (first grant goes to requester 0), `busy`=0, `overrun`=0, `echo_fault`=0; symbol counter=0.
- `req` to `grant`: `req` is sampled at `sym_tick`; `grant` is visible the following cycle. Worst case SYM_CLKS cycles.
- `key` to `mod_out`: 1 cycle while owning.
- Minimum owner-to-owner gap: GUARD_SYMBOLS+1 symbols, counting the IDLE arbitration tick.
- `mod_out`=0 is guaranteed from the cycle `grant` drops.
- Simultaneous requests: strict round-robin. A lone requester is re-granted after the guard.

## Structure
- `proc_modem_pkg`: state typedef, default SYM_CLKS, and the `next_rr` index function.
- One sub-module: `proc_modem_rr_pick`, a combinational round-robin picker. Inputs `req` and last `owner`; outputs a one-hot pick and its index. The FSM, counters and echo check stay in `proc_modem_sched`.

## Test plan
- Single requester: `req[2]`=1 and `key[2]` toggled every 64 clocks after reset. `grant`=4'b0100 one cycle after the first `sym_tick`, and `mod_out` follows `key[2]` with 1-cycle lag.
- All four requesting, each dropping `req` after 3 symbols: grants in order 0,1,2,3,0. Each owner is separated by exactly 3 symbols (96 clocks) of `mod_out`=0.
- Hold overrun: `req[1]` held continuously. Forced release after 64 symbols, `overrun` pulses once, GUARD lasts 2 symbols, then re-grant to 1.
- Echo fault: key 1 with `demod_in` stuck 0. `echo_fault` set at the 4th `sym_tick`. `fault_clr` clears it. Repeating with `demod_in` high after 2 symbols sets no fault.
- `enable` dropped mid-HOLD: `grant`=0 and `mod_out`=0 next clock, with no `overrun`.
- `reset_n` asserted mid-HOLD: outputs take reset values asynchronously. After release the first grant goes to requester 0.
